// File: rtl/alu_vec_checker_if.sv
// Host/DUT-facing bundle of alu_vec_checker: vector load port, run control,
// stimulus/response to the datapath under test and run results.
interface alu_vec_checker_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4,
    parameter int unsigned DEPTH = 128
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned VW = OPW + 3 * WIDTH;

    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [VW-1:0]    load_data;
    logic             start;
    logic [AW:0]      num_vec;
    logic [OPW-1:0]   dut_op;
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic [WIDTH-1:0] dut_result;
    logic             dut_zero;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      err_cnt;
    logic [AW:0]      vec_cnt;
    logic [AW-1:0]    first_err_idx;
    logic             first_err_vld;

    // Host side: loads vectors, starts runs, and hosts the datapath under test
    modport master (
        output load_en, load_addr, load_data, start, num_vec, dut_result, dut_zero,
        input  dut_op, dut_a, dut_b, busy, done, pass, err_cnt, vec_cnt,
               first_err_idx, first_err_vld
    );

    // Checker side
    modport slave (
        input  load_en, load_addr, load_data, start, num_vec, dut_result, dut_zero,
        output dut_op, dut_a, dut_b, busy, done, pass, err_cnt, vec_cnt,
               first_err_idx, first_err_vld
    );
endinterface

// File: rtl/alu_vec_checker.sv
// Self-checking vector engine: streams RAM-held {op,a,b,exp} vectors to a datapath
// and compares result/zero. Optional macro ALU_CHECK_STOP_ON_ERR_EN ends a run at the first mismatch.
module alu_vec_checker #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned OPW    = 4,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_vec_checker_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef ALU_CHECK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t           state;
    state_t           state_d;
    vec_t             ram [DEPTH];
    logic [AW-1:0]    idx;
    logic [AW:0]      num_q;
    logic [CW-1:0]    wait_cnt;
    logic [WIDTH-1:0] exp_q;
    logic [15:0]      err_d;
    logic [AW:0]      num_clamp_c;
    logic             idle_c;
    logic             start_c;
    logic             mismatch_c;
    logic             last_c;

    // Next-state and run-control decode
    always_comb begin
        state_d     = state;
        idle_c      = (state == S_IDLE) || (state == S_DONE);
        start_c     = idle_c && bus.start;
        num_clamp_c = (bus.num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_vec;
        mismatch_c  = (bus.dut_result != exp_q) || (bus.dut_zero != ~|exp_q);
        last_c      = ({1'b0, idx} == (num_q - (AW+1)'(1)));
        err_d       = bus.err_cnt;

        if (start_c) begin
            err_d = 16'h0000;
        end else if ((state == S_CHECK) && mismatch_c && (bus.err_cnt != 16'hFFFF)) begin
            err_d = bus.err_cnt + 16'd1;
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) state_d = (num_clamp_c == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == CW'(SETTLE - 1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (last_c || (STOP_ON_ERR && mismatch_c)) state_d = S_DONE;
                else                                       state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Vector RAM is deliberately not reset so a board reset keeps the loaded set
    always_ff @(posedge clk) begin
        if (bus.load_en && idle_c) ram[bus.load_addr] <= vec_t'(bus.load_data);
    end

    // Stimulus, compare bookkeeping and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dut_op        <= '0;
            bus.dut_a         <= '0;
            bus.dut_b         <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.pass          <= 1'b0;
            bus.err_cnt       <= '0;
            bus.vec_cnt       <= '0;
            bus.first_err_idx <= '0;
            bus.first_err_vld <= 1'b0;
            idx               <= '0;
            num_q             <= '0;
            wait_cnt          <= '0;
            exp_q             <= '0;
        end else begin
            bus.busy    <= (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_CHECK);
            bus.done    <= (state_d == S_DONE);
            bus.pass    <= (state_d == S_DONE) && (err_d == 16'h0000);
            bus.err_cnt <= err_d;

            if (start_c) begin
                bus.vec_cnt       <= '0;
                bus.first_err_vld <= 1'b0;
                idx               <= '0;
                num_q             <= num_clamp_c;
            end

            if (state == S_FETCH) begin
                bus.dut_op <= ram[idx].op;
                bus.dut_a  <= ram[idx].a;
                bus.dut_b  <= ram[idx].b;
                exp_q      <= ram[idx].exp;
                wait_cnt   <= '0;
            end

            if (state == S_WAIT) wait_cnt <= wait_cnt + CW'(1);

            if (state == S_CHECK) begin
                bus.vec_cnt <= bus.vec_cnt + (AW+1)'(1);
                idx         <= idx + AW'(1);
                if (mismatch_c && !bus.first_err_vld) begin
                    bus.first_err_idx <= idx;
                    bus.first_err_vld <= 1'b1;
                end
            end
        end
    end
endmodule
